// File: rtl/riscv_icache_resp_pkg.sv
// Shared definitions for the instruction-cache responder: FSM state codes,
// the NOP returned on error, and line-address helper.
package riscv_icache_resp_pkg;

    typedef enum logic [1:0] {
        ICACHE_IDLE    = 2'd0,
        ICACHE_REFILL  = 2'd1,
        ICACHE_RESPOND = 2'd2
    } icache_state_t;

    // addi x0,x0,0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_words);
        return addr & ~(32'(line_words * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/riscv_icache_resp_array.sv
// Direct-mapped storage: per-line valid bit, tag and data words.
// One write port, one combinational read port, flush clears every valid bit.
module riscv_icache_resp_array #(
    parameter int  LINE_WORDS = 4,
    parameter int  NUM_LINES  = 16,
    parameter int  TAG_W      = 24,
    localparam int WORD_W     = $clog2(LINE_WORDS),
    localparam int IDX_W      = $clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_all,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              tag_wr,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              valid_in,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES*LINE_WORDS];

    // Flush outranks a same-cycle valid write, so a line refilled under a flush stays invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (tag_wr) begin
            valid[wr_index] <= valid_in;
        end
    end

    // NOTE: tag and data arrays carry no reset; only valid bits must be known after reset.
    always_ff @(posedge clk) begin
        if (tag_wr) begin
            tags[wr_index] <= tag_in;
        end
        if (wr_en) begin
            data[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_word}];

endmodule

// File: rtl/riscv_icache_resp.sv
// Instruction-fetch responder: direct-mapped I-cache with whole-line refill
// from backing memory over a req/ack word interface.
module riscv_icache_resp
    import riscv_icache_resp_pkg::*;
#(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 16,
    parameter logic [31:0] NOP_INST   = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int IDX_LSB = 2 + WORD_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    icache_state_t     state, next_state;
    logic [31:2]       addr_q;
    logic [WORD_W-1:0] cnt;
    logic              flush_seen;

    logic              handshake, misaligned, hit, ack, last_ack;
    logic              start_miss, resp_hit, resp_misaligned, resp_refill;
    logic              tag_wr, valid_in;
    logic [IDX_W-1:0]  req_index, q_index, cur_index;
    logic [WORD_W-1:0] req_word, q_word, cur_word;
    logic [TAG_W-1:0]  req_tag, q_tag, cur_tag, rd_tag;
    logic              rd_valid;
    logic [31:0]       rd_data;

    assign req_index = req_addr[TAG_LSB-1:IDX_LSB];
    assign req_word  = req_addr[IDX_LSB-1:2];
    assign req_tag   = req_addr[31:TAG_LSB];
    assign q_index   = addr_q[TAG_LSB-1:IDX_LSB];
    assign q_word    = addr_q[IDX_LSB-1:2];
    assign q_tag     = addr_q[31:TAG_LSB];

    // In IDLE the array is probed with the incoming address; otherwise with the latched one.
    assign cur_index = (state == ICACHE_IDLE) ? req_index : q_index;
    assign cur_word  = (state == ICACHE_IDLE) ? req_word  : q_word;
    assign cur_tag   = (state == ICACHE_IDLE) ? req_tag   : q_tag;

    assign req_ready  = !rst && (state == ICACHE_IDLE) && !flush;
    assign handshake  = req_valid && req_ready;
    assign misaligned = |req_addr[1:0];
    assign hit        = rd_valid && (rd_tag == req_tag);
    assign ack        = mem_req && mem_ack;
    assign last_ack   = ack && (cnt == WORD_W'(LINE_WORDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ICACHE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ICACHE_IDLE:    if (start_miss) next_state = ICACHE_REFILL;
            ICACHE_REFILL:  if (last_ack) next_state = ICACHE_RESPOND;
            ICACHE_RESPOND: next_state = ICACHE_IDLE;
            default:        next_state = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        start_miss      = 1'b0;
        resp_hit        = 1'b0;
        resp_misaligned = 1'b0;
        resp_refill     = 1'b0;
        tag_wr          = 1'b0;
        valid_in        = 1'b0;
        case (state)
            ICACHE_IDLE: begin
                if (handshake) begin
                    if (misaligned) begin
                        resp_misaligned = 1'b1;
                    end else if (hit) begin
                        resp_hit = 1'b1;
                    end else begin
                        // Invalidate up front so an aborted refill never leaves a stale hit.
                        start_miss = 1'b1;
                        tag_wr     = 1'b1;
                    end
                end
            end
            ICACHE_REFILL: begin
                if (last_ack) begin
                    tag_wr   = 1'b1;
                    valid_in = !flush_seen;
                end
            end
            ICACHE_RESPOND: resp_refill = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            cnt        <= '0;
            flush_seen <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= resp_hit | resp_misaligned | resp_refill;
            resp_err   <= resp_misaligned;
            if (resp_misaligned) begin
                resp_inst <= NOP_INST;
            end else if (resp_hit || resp_refill) begin
                resp_inst <= rd_data;
            end
            if (handshake) begin
                addr_q <= req_addr[31:2];
            end
            if (start_miss) begin
                cnt        <= '0;
                flush_seen <= 1'b0;
                mem_req    <= 1'b1;
                mem_addr   <= line_base(req_addr, LINE_WORDS);
            end
            if (ack) begin
                cnt <= cnt + 1'b1;
                if (last_ack) begin
                    mem_req <= 1'b0;
                end else begin
                    mem_addr <= mem_addr + 32'd4;
                end
            end
            if (state == ICACHE_REFILL && flush) begin
                flush_seen <= 1'b1;
            end
        end
    end

    riscv_icache_resp_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .flush_all (flush),
        .wr_en     (ack),
        .wr_index  (cur_index),
        .wr_word   (cnt),
        .wr_data   (mem_rdata),
        .tag_wr    (tag_wr),
        .tag_in    (cur_tag),
        .valid_in  (valid_in),
        .rd_index  (cur_index),
        .rd_word   (cur_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_riscv_icache_resp.sv
// Directed bench for riscv_icache_resp: miss/hit/conflict/misaligned/flush/reset
// scenarios against a backing memory that returns rdata = address.
module tb_riscv_icache_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, flush;
    logic [31:0] req_addr;
    logic        req_ready, resp_valid, resp_err, mem_req;
    logic [31:0] resp_inst, mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_log [64];
    int          mem_n    = 0;
    int          ack_wait = 0;
    int          wait_cnt = 0;

    riscv_icache_resp dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing memory: acks each word after ack_wait idle cycles, data equals address.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (rst !== 1'b1 && mem_req === 1'b1) begin
            if (wait_cnt >= ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr;
                mem_log[mem_n % 64] = mem_addr;
                mem_n++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one request in the next cycle; returns 1 time unit after its handshake edge.
    task automatic issue(input string tag, input logic [31:0] addr);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        #1 check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Waits for resp_valid; 'start' is the cycle count since handshake at entry.
    task automatic wait_resp(input string tag, input int start, input int exp_lat,
                             input logic [31:0] exp_inst);
        int n;
        n = start;
        while (resp_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_inst"}, resp_inst, exp_inst);
        check({tag, ".resp_err"}, 32'(resp_err), 32'd0);
    endtask

    task automatic check_hit(input string tag, input logic [31:0] addr);
        issue(tag, addr);
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_inst"}, resp_inst, addr);
        check({tag, ".resp_err"}, 32'(resp_err), 32'd0);
        check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    endtask

    task automatic check_line_reads(input string tag, input int base, input logic [31:0] line);
        check({tag, ".read_count"}, 32'(mem_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check({tag, ".read_addr"}, mem_log[(base + i) % 64], line + 32'(4 * i));
        end
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_inst", resp_inst, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst.req_ready", 32'(req_ready), 32'd1);

        // 1: cold miss, each ack one cycle late -> response at handshake+10
        ack_wait = 1;
        base = mem_n;
        issue("cold", 32'h10);
        check("cold.mem_req", 32'(mem_req), 32'd1);
        check("cold.mem_addr", mem_addr, 32'h10);
        wait_resp("cold", 1, 10, 32'h10);
        check_line_reads("cold", base, 32'h10);

        // 2: back-to-back hits in the refilled line
        base = mem_n;
        check_hit("hit14", 32'h14);
        check_hit("hit18", 32'h18);
        check_hit("hit1c", 32'h1C);
        check("hits.no_reads", 32'(mem_n - base), 32'd0);

        // 3: conflict on index 1, zero-wait memory -> latency 6
        ack_wait = 0;
        base = mem_n;
        issue("conf110", 32'h110);
        wait_resp("conf110", 1, 6, 32'h110);
        check_line_reads("conf110", base, 32'h110);
        base = mem_n;
        issue("conf10", 32'h10);
        wait_resp("conf10", 1, 6, 32'h10);
        check_line_reads("conf10", base, 32'h10);

        // 4: misaligned request into a valid line
        base = mem_n;
        issue("misal", 32'h12);
        check("misal.resp_valid", 32'(resp_valid), 32'd1);
        check("misal.resp_err", 32'(resp_err), 32'd1);
        check("misal.resp_inst", resp_inst, 32'h13);
        check("misal.mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1 check("misal.pulse", 32'(resp_valid), 32'd0);
        check("misal.no_reads", 32'(mem_n - base), 32'd0);

        // 5a: flush beats a same-cycle request, then the warm line misses
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        #1 check("flush.req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 check("flush.no_resp", 32'(resp_valid), 32'd0);
        flush     = 1'b0;
        req_valid = 1'b0;
        base = mem_n;
        issue("flush_miss", 32'h10);
        wait_resp("flush_miss", 1, 6, 32'h10);
        check("flush_miss.reads", 32'(mem_n - base), 32'd4);

        // 5b: flush during refill -> response delivered, line left invalid
        ack_wait = 1;
        issue("fl_refill", 32'h20);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1 wait_resp("fl_refill", 3, 10, 32'h20);
        base = mem_n;
        issue("fl_again", 32'h20);
        wait_resp("fl_again", 1, 10, 32'h20);
        check_line_reads("fl_again", base, 32'h20);

        // 6: reset after two acks of a refill
        ack_wait = 0;
        base = mem_n;
        issue("rstmid", 32'h10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 check("rstmid.acks", 32'(mem_n - base), 32'd2);
        rst = 1'b1;
        #1;
        check("rstmid.mem_req", 32'(mem_req), 32'd0);
        check("rstmid.req_ready", 32'(req_ready), 32'd0);
        check("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("rstmid.no_resp", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 check("rstmid.ready_back", 32'(req_ready), 32'd1);
        base = mem_n;
        issue("rst_miss", 32'h10);
        wait_resp("rst_miss", 1, 6, 32'h10);
        check_line_reads("rst_miss", base, 32'h10);
        check_hit("rst_hit", 32'h1C);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
